// File: rtl/bank_cmd_scheduler_if.sv
// bank_cmd_scheduler_if: requester, refresh, command and completion signals of one bank scheduler
interface bank_cmd_scheduler_if #(
  parameter int ROWS = 131072,
  parameter int COLS = 1024
);
  logic                     req0_valid, req0_we, req0_ready;
  logic [$clog2(ROWS)-1:0]  req0_row;
  logic [$clog2(COLS)-1:0]  req0_col;
  logic                     req1_valid, req1_we, req1_ready;
  logic [$clog2(ROWS)-1:0]  req1_row;
  logic [$clog2(COLS)-1:0]  req1_col;
  logic                     ref_req, ref_ack;
  logic [18:0]              commands;
  logic [$clog2(ROWS)-1:0]  row;
  logic [$clog2(COLS)-1:0]  column;
  logic                     done_valid, done_id, done_we, row_open;
  modport master (
    output req0_valid, req0_we, req0_row, req0_col,
    output req1_valid, req1_we, req1_row, req1_col, ref_req,
    input  req0_ready, req1_ready, ref_ack, commands, row, column,
    input  done_valid, done_id, done_we, row_open
  );
  modport slave (
    input  req0_valid, req0_we, req0_row, req0_col,
    input  req1_valid, req1_we, req1_row, req1_col, ref_req,
    output req0_ready, req1_ready, ref_ack, commands, row, column,
    output done_valid, done_id, done_we, row_open
  );
endinterface

// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler: open-row single-bank scheduler, round-robin over two requesters plus refresh
module bank_cmd_scheduler #(
  parameter int ROWS  = 131072,
  parameter int COLS  = 1024,
  parameter int BL    = 8,
  parameter int T_RP  = 3,
  parameter int T_RCD = 3,
  parameter int T_CL  = 4,
  parameter int T_WR  = 2,
  parameter int T_RFC = 10
) (
  input logic clk,
  input logic reset_n,
  input logic halt,
  bank_cmd_scheduler_if.slave bus
);
  localparam int RW    = $clog2(ROWS);
  localparam int CLW   = $clog2(COLS);
  localparam int D_RP  = T_RP - 1;
  localparam int D_RCD = T_RCD - 1;
  localparam int D_RD  = T_CL + BL;
  localparam int D_WR  = BL + T_WR;
  localparam int D_RFC = T_RFC - 1;
  localparam int M1    = D_RD > D_WR ? D_RD : D_WR;
  localparam int M2    = D_RFC > M1 ? D_RFC : M1;
  localparam int M3    = D_RP > M2 ? D_RP : M2;
  localparam int MAXW  = D_RCD > M3 ? D_RCD : M3;
  localparam int CW    = $clog2(MAXW + 1);
  // counter holds remaining cycles minus one, so a state lasting D cycles loads D-1
  localparam logic [CW-1:0] L_RP  = CW'(D_RP > 0 ? D_RP - 1 : 0);
  localparam logic [CW-1:0] L_RCD = CW'(D_RCD > 0 ? D_RCD - 1 : 0);
  localparam logic [CW-1:0] L_RD  = CW'(D_RD - 1);
  localparam logic [CW-1:0] L_WR  = CW'(D_WR - 1);
  localparam logic [CW-1:0] L_RFC = CW'(D_RFC > 0 ? D_RFC - 1 : 0);

  typedef enum logic [3:0] {IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CAS, CAS_WAIT, REF, REF_WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic row_open, rr_last, l_we, l_id, for_ref, run, grant, gid;
  logic [RW-1:0] open_row, l_row, req_row;
  logic [CLW-1:0] l_col;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      row_open <= 1'b0;
      open_row <= '0;
      rr_last  <= 1'b1;
      l_we     <= 1'b0;
      l_id     <= 1'b0;
      l_row    <= '0;
      l_col    <= '0;
      for_ref  <= 1'b0;
    end else if (!halt) begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE) for_ref <= bus.ref_req;
      if (grant) begin
        rr_last <= gid;
        l_id    <= gid;
        l_we    <= gid ? bus.req1_we : bus.req0_we;
        l_row   <= req_row;
        l_col   <= gid ? bus.req1_col : bus.req0_col;
      end
      if (state == PRE) row_open <= 1'b0;
      if (state == ACT) begin
        row_open <= 1'b1;
        open_row <= l_row;
      end
    end

  // outputs are gated by run so halted cycles stay silent and the pulse reappears once unhalted
  always_comb begin
    run            = reset_n && !halt;
    gid            = (bus.req0_valid && bus.req1_valid) ? !rr_last : bus.req1_valid;
    req_row        = gid ? bus.req1_row : bus.req0_row;
    state_nx       = state;
    cnt_nx         = cnt;
    grant          = 1'b0;
    bus.commands   = '0;
    bus.row        = '0;
    bus.column     = '0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.done_valid = 1'b0;
    bus.done_id    = 1'b0;
    bus.done_we    = 1'b0;
    bus.ref_ack    = 1'b0;
    bus.row_open   = row_open;
    if (run)
      case (state)
        IDLE:
          if (bus.ref_req) state_nx = row_open ? PRE : REF;
          else if (bus.req0_valid || bus.req1_valid) begin
            grant          = 1'b1;
            bus.req0_ready = !gid;
            bus.req1_ready = gid;
            state_nx       = !row_open ? ACT : (req_row == open_row ? CAS : PRE);
          end
        PRE: begin
          bus.commands[7] = 1'b1;
          state_nx        = D_RP == 0 ? (for_ref ? REF : ACT) : PRE_WAIT;
          cnt_nx          = L_RP;
        end
        PRE_WAIT: begin
          state_nx = cnt == '0 ? (for_ref ? REF : ACT) : PRE_WAIT;
          cnt_nx   = cnt - 1'b1;
        end
        ACT: begin
          bus.commands[18] = 1'b1;
          bus.row          = l_row;
          state_nx         = D_RCD == 0 ? CAS : ACT_WAIT;
          cnt_nx           = L_RCD;
        end
        ACT_WAIT: begin
          state_nx = cnt == '0 ? CAS : ACT_WAIT;
          cnt_nx   = cnt - 1'b1;
        end
        CAS: begin
          bus.commands[5] = !l_we;
          bus.commands[1] = l_we;
          bus.column      = l_col;
          state_nx        = CAS_WAIT;
          cnt_nx          = l_we ? L_WR : L_RD;
        end
        CAS_WAIT: begin
          bus.done_valid = cnt == '0;
          bus.done_id    = cnt == '0 && l_id;
          bus.done_we    = cnt == '0 && l_we;
          state_nx       = cnt == '0 ? IDLE : CAS_WAIT;
          cnt_nx         = cnt - 1'b1;
        end
        REF: begin
          bus.commands[3] = 1'b1;
          bus.ref_ack     = D_RFC == 0;
          state_nx        = D_RFC == 0 ? IDLE : REF_WAIT;
          cnt_nx          = L_RFC;
        end
        REF_WAIT: begin
          bus.ref_ack = cnt == '0;
          state_nx    = cnt == '0 ? IDLE : REF_WAIT;
          cnt_nx      = cnt - 1'b1;
        end
        default: state_nx = IDLE;
      endcase
  end
endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// tb_bank_cmd_scheduler: random requests/refresh/halt scored against a transaction-level timing model
module tb_bank_cmd_scheduler;
  localparam int ROWS = 131072, COLS = 1024, BL = 8;
  localparam int T_RP = 3, T_RCD = 3, T_CL = 4, T_WR = 2, T_RFC = 10;
  localparam int RW = $clog2(ROWS), CLW = $clog2(COLS);
  localparam logic [18:0] C_ACT = 19'd1 << 18, C_PR = 19'd1 << 7, C_RD = 19'd1 << 5;
  localparam logic [18:0] C_REF = 19'd1 << 3, C_WR = 19'd1 << 1;

  logic clk = 1'b0, reset_n = 1'b0, halt = 1'b0;
  always #5 clk = ~clk;

  bank_cmd_scheduler_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  bank_cmd_scheduler #(.ROWS(ROWS), .COLS(COLS), .BL(BL), .T_RP(T_RP), .T_RCD(T_RCD),
    .T_CL(T_CL), .T_WR(T_WR), .T_RFC(T_RFC)) dut (.clk(clk), .reset_n(reset_n), .halt(halt), .bus(bus));

  typedef struct {
    int t;
    logic [18:0] cmd;
    logic [RW-1:0] row;
    logic [CLW-1:0] col;
    logic r0, r1, dv, did, dwe, ack, ro;
  } ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  int ucount = 0, cur_t = 0, free_at = 0, ref_ack_t = 0;
  bit m_open = 0, m_rr = 1, mon_en = 0, ref_on = 0, clr0 = 0, clr1 = 0;
  logic [RW-1:0] m_row = '0;

  function automatic logic [63:0] pk(logic [18:0] c, logic [RW-1:0] r, logic [CLW-1:0] co,
                                     logic r0, logic r1, logic dv, logic did, logic dwe, logic ack, logic ro);
    return {11'b0, c, r, co, r0, r1, dv, did, dwe, ack, ro};
  endfunction

  function automatic logic [63:0] dut_vec(logic with_ro);
    return pk(bus.commands, bus.row, bus.column, bus.req0_ready, bus.req1_ready, bus.done_valid,
              bus.done_id, bus.done_we, bus.ref_ack, with_ro & bus.row_open);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, cur_t, got, exp);
    end
  endtask

  task automatic push(input int t, input logic [18:0] cmd, input logic [RW-1:0] row, input logic [CLW-1:0] col,
                      input logic r0, input logic r1, input logic dv, input logic did, input logic dwe,
                      input logic ack, input logic ro);
    ev_t e;
    e.t = t; e.cmd = cmd; e.row = row; e.col = col; e.r0 = r0; e.r1 = r1;
    e.dv = dv; e.did = did; e.dwe = dwe; e.ack = ack; e.ro = ro;
    q.push_back(e);
  endtask

  // Reference: each granted job occupies the bank for a fixed span computed from the timing rules.
  task automatic decide(input int t);
    int a, c, d;
    bit id, we, hit;
    logic [RW-1:0] r;
    logic [CLW-1:0] co;
    if (t < free_at) return;
    if (bus.ref_req) begin
      if (m_open) begin
        push(t + 1, C_PR, '0, '0, 0, 0, 0, 0, 0, 0, 1);
        a = t + 1 + T_RP;
      end else a = t + 1;
      push(a, C_REF, '0, '0, 0, 0, 0, 0, 0, T_RFC == 1, 0);
      if (T_RFC > 1) push(a + T_RFC - 1, '0, '0, '0, 0, 0, 0, 0, 0, 1, 0);
      ref_ack_t = a + T_RFC - 1;
      free_at = ref_ack_t + 1;
      m_open = 0;
    end else if (bus.req0_valid || bus.req1_valid) begin
      id = (bus.req0_valid && bus.req1_valid) ? !m_rr : bus.req1_valid;
      m_rr = id;
      we = id ? bus.req1_we : bus.req0_we;
      r = id ? bus.req1_row : bus.req0_row;
      co = id ? bus.req1_col : bus.req0_col;
      push(t, '0, '0, '0, !id, id, 0, 0, 0, 0, m_open);
      hit = m_open && m_row == r;
      if (hit) c = t + 1;
      else begin
        if (m_open) begin
          push(t + 1, C_PR, '0, '0, 0, 0, 0, 0, 0, 0, 1);
          a = t + 1 + T_RP;
        end else a = t + 1;
        push(a, C_ACT, r, '0, 0, 0, 0, 0, 0, 0, 0);
        c = a + T_RCD;
      end
      push(c, we ? C_WR : C_RD, '0, co, 0, 0, 0, 0, 0, 0, 1);
      d = c + (we ? BL + T_WR : T_CL + BL);
      push(d, '0, '0, '0, 0, 0, 1, id, we, 0, 1);
      free_at = d + 1;
      m_open = 1;
      m_row = r;
      if (id) clr1 = 1; else clr0 = 1;
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    int s = $urandom_range(0, 3);
    return s == 0 ? RW'(5) : s == 1 ? RW'(9) : s == 2 ? m_row : RW'($urandom);
  endfunction

  task automatic cycle(input bit gen, input bit allow_halt, input bit force0);
    @(negedge clk);
    if (clr0) begin bus.req0_valid = 0; clr0 = 0; end
    if (clr1) begin bus.req1_valid = 0; clr1 = 0; end
    if (ref_on && ucount > ref_ack_t) begin bus.ref_req = 0; ref_on = 0; end
    if (gen && !ref_on && $urandom_range(0, 39) == 0) begin
      bus.ref_req = 1; ref_on = 1; ref_ack_t = 32'h7fffffff;
    end
    if (force0) begin
      bus.req0_valid = 1; bus.req0_we = 0; bus.req0_row = RW'(5); bus.req0_col = CLW'(16);
    end
    if (gen && !bus.req0_valid && $urandom_range(0, 3) == 0) begin
      bus.req0_valid = 1; bus.req0_we = 1'($urandom); bus.req0_row = rand_row(); bus.req0_col = CLW'($urandom);
    end
    if (gen && !bus.req1_valid && $urandom_range(0, 3) == 0) begin
      bus.req1_valid = 1; bus.req1_we = 1'($urandom); bus.req1_row = rand_row(); bus.req1_col = CLW'($urandom);
    end
    halt = allow_halt && $urandom_range(0, 7) == 0;
    if (!halt) begin
      cur_t = ucount;
      decide(ucount);
      ucount++;
    end
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        if (halt) check("halt_quiet", dut_vec(0), '0);
        else begin
          while (q.size() > 0 && q[0].t < cur_t) begin
            e = q.pop_front();
            checks++; errors++;
            $display("FAIL missed_event: expected at t=%0d, still absent at t=%0d", e.t, cur_t);
          end
          if (dut_vec(0) != '0) begin
            if (q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_output t=%0d: got %0h expected none", cur_t, dut_vec(1));
            end else begin
              e = q.pop_front();
              check("event_time", 64'(cur_t), 64'(e.t));
              check("event_out", dut_vec(1), pk(e.cmd, e.row, e.col, e.r0, e.r1, e.dv, e.did, e.dwe, e.ack, e.ro));
            end
          end
        end
      end
    end
  end

  initial begin
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_row = '0; bus.req0_col = '0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_row = '0; bus.req1_col = '0;
    bus.ref_req = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", dut_vec(1), '0);
    check("reset_row_open", 64'(bus.row_open), 0);
    @(negedge clk);
    reset_n = 1;
    mon_en = 1;
    cycle(0, 0, 1);
    repeat (3000) cycle(1, 1, 0);
    for (int i = 0; i < 400 && (ucount <= free_at || q.size() > 0 || bus.req0_valid || bus.req1_valid || bus.ref_req); i++)
      cycle(0, 0, 0);
    @(negedge clk);
    #4;
    check("drain_queue_empty", 64'(q.size()), 0);
    check("drain_no_pending", {62'b0, bus.req0_valid, bus.req1_valid}, 0);
    mon_en = 0;
    @(negedge clk);
    halt = 0;
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_row = m_row + 1'b1; bus.req0_col = CLW'(3);
    @(negedge clk);
    bus.req0_valid = 0;
    repeat (9) @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("async_reset_outputs", dut_vec(1), '0);
    check("async_reset_row_open", 64'(bus.row_open), 0);
    repeat (3) begin
      @(negedge clk);
      #3 check("reset_held_quiet", dut_vec(1), '0);
    end
    reset_n = 1;
    repeat (20) begin
      @(negedge clk);
      #3 check("post_reset_quiet", dut_vec(1), '0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
